ball_ctl: RTL and testbench
===========================

// Module: ball_ctl
// PURPOSE
//  Ball motion controller for Arkanoid; sits directly upstream of the ball drawing stage and feeds it
//  ball_x/ball_y, the ball-centre position in screen pixels (ball_x compared with hcount, ball_y with vcount).
//  Once per frame it moves the ball, bounces it off the left/right/top walls and the paddle,
//  detects a miss, and tracks lives and the IDLE/MOVE/LOST/OVER game state.
// PARAMETERS
//  SCREEN_W  800  visible width in pixels
//  SCREEN_H  600  visible height in pixels
//  BALL_R    10   ball radius in pixels
//  STEP      4    pixels moved per axis per frame
//  PADDLE_Y  560  y of the paddle top edge
//  PADDLE_W  80   paddle width in pixels; paddle_x is the left edge
//  X_INIT    400  ball_x after reset
//  LIVES     3    lives at reset and on restart (1..3)
// PORTS
//  pclk        in   1   pixel clock
//  reset       in   1   asynchronous reset, ACTIVE-LOW
//  vblnk_in    in   1   vertical blank from the timing stage; its rising edge is the frame tick
//  start       in   1   launch/restart request, level, sampled only on a frame tick
//  paddle_x    in   11  paddle left edge, x
//  ball_x      out  11  ball centre x, registered
//  ball_y      out  11  ball centre y, registered
//  ball_lost   out  1   one-pclk pulse when the ball is missed
//  lives       out  2   remaining lives, registered
//  game_state  out  2   0=IDLE 1=MOVE 2=LOST 3=OVER, registered
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, ball_x=X_INIT, ball_y=PADDLE_Y-BALL_R-1 (549),
//   dir_x=1 (+x), dir_y=0 (up), ball_lost=0, lives=LIVES, vblnk_d=0.
//  vblnk_d <= vblnk_in every pclk. tick = vblnk_in & ~vblnk_d.
//   All state/position updates happen only on the pclk edge where tick=1 (latency 1 pclk).
//  All arithmetic is done in 12 bits unsigned. Each subtraction is guarded by a compare, so nothing underflows.
//  IDLE: on tick, ball_x=paddle_x+PADDLE_W/2 and ball_y=PADDLE_Y-BALL_R-1.
//   If start=1, go to MOVE with dir_x=1 and dir_y=0. Position does not step on that tick.
//  MOVE, on tick, x and y are evaluated independently in the same tick, so a corner flips both dirs:
//   x: if dir_x=1 and x+STEP>SCREEN_W-1-BALL_R, then x=SCREEN_W-1-BALL_R and dir_x=0.
//      else if dir_x=0 and x<BALL_R+STEP, then x=BALL_R and dir_x=1. else x=x+/-STEP.
//   y up: if y<BALL_R+STEP, then y=BALL_R and dir_y=1. else y=y-STEP.
//   y down: paddle hit when y+BALL_R<PADDLE_Y, y+STEP+BALL_R>=PADDLE_Y,
//      and paddle_x<=x_old<=paddle_x+PADDLE_W-1. Then y=PADDLE_Y-BALL_R-1 and dir_y=0.
//      else if y+STEP>SCREEN_H-1-BALL_R, then y=SCREEN_H-1-BALL_R, ball_lost=1 for this one pclk,
//      lives=lives-1, and go to LOST. else y=y+STEP.
//  LOST: position frozen. On the next tick, go to OVER if lives==0, else go to IDLE (same tick rules as IDLE).
//  OVER: position frozen. On a tick with start=1: lives=LIVES, go to IDLE, and ball re-centred on the paddle.
//  start is ignored in MOVE and LOST. A tick with vblnk held high does not re-trigger.
//  ball_lost is 0 on every other cycle. lives saturates at 0.
//  Reset asserted mid-frame or mid-MOVE forces the reset values immediately, without waiting for a clock edge.
// TESTING
//  1 reset=0 then released, paddle_x=360, 3 ticks, start=0
//    -> IDLE, ball_x=400, ball_y=549, lives=3, ball_lost=0 throughout.
//  2 paddle_x=100, tick -> ball_x=140; start=1 on the next tick -> MOVE;
//    on the following tick ball_x=144, ball_y=545.
//  3 MOVE, x=786, dir_x=1, tick -> x=789, dir_x=0; next tick -> x=785.
//    Corner: x=12, y=12, up-left -> x=10, y=10, dir_x=1, dir_y=1.
//  4 down, y=547, x=400, paddle_x=360 -> y=549, dir_y=0.
//    Same with paddle_x=0 -> y steps to 551..587, then y=589, one-pclk ball_lost, lives=2, LOST;
//    next tick -> IDLE.
//  5 three misses -> lives=0, OVER, position frozen.
//    start=1 between ticks does nothing; start=1 on a tick -> IDLE, lives=3.
//  6 reset pulsed low between clock edges during MOVE -> outputs take reset values at once;
//    vblnk_in held high for 10 pclk -> exactly one update.

Source files
------------

// File: rtl/ball_ctl.sv
// Ball motion controller: steps the ball once per frame,
// bounces it off walls and paddle, and tracks lives and game state.
module ball_ctl #(
  parameter int SCREEN_W = 800,
  parameter int SCREEN_H = 600,
  parameter int BALL_R   = 10,
  parameter int STEP     = 4,
  parameter int PADDLE_Y = 560,
  parameter int PADDLE_W = 80,
  parameter int X_INIT   = 400,
  parameter int LIVES    = 3
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        vblnk_in,
  input  logic        start,
  input  logic [10:0] paddle_x,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic        ball_lost,
  output logic [1:0]  lives,
  output logic [1:0]  game_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_LOST = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  localparam logic [11:0] C_STEP  = 12'(STEP);
  localparam logic [11:0] C_R     = 12'(BALL_R);
  localparam logic [11:0] C_HALF  = 12'(PADDLE_W / 2);
  localparam logic [11:0] C_PW1   = 12'(PADDLE_W - 1);
  localparam logic [11:0] C_PY    = 12'(PADDLE_Y);
  localparam logic [11:0] C_X_MAX = 12'(SCREEN_W - 1 - BALL_R);
  localparam logic [11:0] C_Y_MAX = 12'(SCREEN_H - 1 - BALL_R);
  localparam logic [11:0] C_LOW   = 12'(BALL_R + STEP);
  localparam logic [10:0] C_Y_PAD = 11'(PADDLE_Y - BALL_R - 1);
  localparam logic [10:0] C_X_INI = 11'(X_INIT);
  localparam logic [1:0]  C_LIVES = 2'(LIVES);

  logic [1:0]  state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        dir_x_q, dir_x_d;
  logic        dir_y_q, dir_y_d;
  logic        lost_q, lost_d;
  logic [1:0]  lives_q, lives_d;
  logic        vblnk_q;

  logic        tick;
  logic [11:0] px12, x12, y12, centre;
  logic        pad_hit;

  assign tick   = vblnk_in & ~vblnk_q;
  assign px12   = {1'b0, paddle_x};
  assign x12    = {1'b0, x_q};
  assign y12    = {1'b0, y_q};
  assign centre = px12 + C_HALF;

  assign pad_hit = (y12 + C_R < C_PY)
                && (y12 + C_STEP + C_R >= C_PY)
                && (x12 >= px12)
                && (x12 <= px12 + C_PW1);

  // Next-state: game FSM plus per-axis ball motion on frame tick
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    lives_d = lives_q;
    lost_d  = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          x_d = centre[10:0];
          y_d = C_Y_PAD;
          if (start) begin
            state_d = S_MOVE;
            dir_x_d = 1'b1;
            dir_y_d = 1'b0;
          end
        end
        S_MOVE: begin
          if (dir_x_q) begin
            if (x12 + C_STEP > C_X_MAX) begin
              x_d     = C_X_MAX[10:0];
              dir_x_d = 1'b0;
            end else begin
              x_d = x_q + C_STEP[10:0];
            end
          end else begin
            if (x12 < C_LOW) begin
              x_d     = C_R[10:0];
              dir_x_d = 1'b1;
            end else begin
              x_d = x_q - C_STEP[10:0];
            end
          end
          if (!dir_y_q) begin
            if (y12 < C_LOW) begin
              y_d     = C_R[10:0];
              dir_y_d = 1'b1;
            end else begin
              y_d = y_q - C_STEP[10:0];
            end
          end else if (pad_hit) begin
            y_d     = C_Y_PAD;
            dir_y_d = 1'b0;
          end else if (y12 + C_STEP > C_Y_MAX) begin
            y_d     = C_Y_MAX[10:0];
            lost_d  = 1'b1;
            lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            state_d = S_LOST;
          end else begin
            y_d = y_q + C_STEP[10:0];
          end
        end
        S_LOST: begin
          if (lives_q == 2'd0) begin
            state_d = S_OVER;
          end else begin
            state_d = S_IDLE;
            x_d     = centre[10:0];
            y_d     = C_Y_PAD;
          end
        end
        default: begin
          if (start) begin
            lives_d = C_LIVES;
            state_d = S_IDLE;
            x_d     = centre[10:0];
            y_d     = C_Y_PAD;
          end
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= C_X_INI;
      y_q     <= C_Y_PAD;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b0;
      lost_q  <= 1'b0;
      lives_q <= C_LIVES;
      vblnk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      lost_q  <= lost_d;
      lives_q <= lives_d;
      vblnk_q <= vblnk_in;
    end
  end

  assign ball_x     = x_q;
  assign ball_y     = y_q;
  assign ball_lost  = lost_q;
  assign lives      = lives_q;
  assign game_state = state_q;

endmodule

// File: tb/tb_ball_ctl.sv
// Randomized scoreboard bench for ball_ctl against
// a frame-level game model.
module tb_ball_ctl;

  logic        pclk = 1'b0;
  logic        reset_n;
  logic        vblnk_in;
  logic        start;
  logic [10:0] paddle_x;
  logic [10:0] ball_x;
  logic [10:0] ball_y;
  logic        ball_lost;
  logic [1:0]  lives;
  logic [1:0]  game_state;

  always #5 pclk = ~pclk;

  ball_ctl dut (
    .pclk      (pclk),
    .reset     (reset_n),
    .vblnk_in  (vblnk_in),
    .start     (start),
    .paddle_x  (paddle_x),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .ball_lost (ball_lost),
    .lives     (lives),
    .game_state(game_state)
  );

  localparam int IDLE = 0;
  localparam int MOVE = 1;
  localparam int LOST = 2;
  localparam int OVER = 3;

  typedef struct {
    int x;
    int y;
    int lives;
    int st;
    int lost;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int m_x, m_y, m_lives, m_st;
  bit m_right, m_down;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = IDLE; m_x = 400; m_y = 549;
    m_right = 1; m_down = 0; m_lives = 3;
  endtask

  // One frame of game play expressed in screen coordinates
  task automatic model_frame(input bit s, input int px);
    exp_t e;
    int old_x;
    int lost;
    lost = 0;
    if (m_st == IDLE) begin
      m_x = (px + 40) % 2048; m_y = 549;
      if (s) begin m_st = MOVE; m_right = 1; m_down = 0; end
    end else if (m_st == MOVE) begin
      old_x = m_x;
      if (m_right) begin
        if (m_x + 4 > 789) begin m_x = 789; m_right = 0; end
        else m_x = m_x + 4;
      end else begin
        if (m_x < 14) begin m_x = 10; m_right = 1; end
        else m_x = m_x - 4;
      end
      if (!m_down) begin
        if (m_y < 14) begin m_y = 10; m_down = 1; end
        else m_y = m_y - 4;
      end else if (m_y + 10 < 560 && m_y + 14 >= 560 &&
                   old_x >= px && old_x <= px + 79) begin
        m_y = 549; m_down = 0;
      end else if (m_y + 4 > 589) begin
        m_y = 589; lost = 1;
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        m_st = LOST;
      end else begin
        m_y = m_y + 4;
      end
    end else if (m_st == LOST) begin
      if (m_lives == 0) m_st = OVER;
      else begin m_st = IDLE; m_x = (px + 40) % 2048; m_y = 549; end
    end else if (s) begin
      m_lives = 3; m_st = IDLE; m_x = (px + 40) % 2048; m_y = 549;
    end
    e.x = m_x; e.y = m_y; e.lives = m_lives; e.st = m_st; e.lost = lost;
    q.push_back(e);
  endtask

  // Bench-side frame tick detection marks when the DUT has an update
  logic vb_prev, upd;
  always @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      vb_prev <= 1'b0;
      upd     <= 1'b0;
    end else begin
      upd     <= vblnk_in & ~vb_prev;
      vb_prev <= vblnk_in;
    end
  end

  // Monitor: pop and compare after each update, else lost must be low
  always @(negedge pclk) begin : mon
    exp_t e;
    if (reset_n === 1'b1) begin
      if (upd) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty actual=update required=none");
        end else begin
          e = q.pop_front();
          chk("ball_x", int'(ball_x), e.x);
          chk("ball_y", int'(ball_y), e.y);
          chk("lives", int'(lives), e.lives);
          chk("game_state", int'(game_state), e.st);
          chk("ball_lost_pulse", int'(ball_lost), e.lost);
        end
      end else begin
        chk("ball_lost_quiet", int'(ball_lost), 0);
      end
    end
  end

  task automatic frame(input bit s, input int px, input int hold);
    @(negedge pclk);
    start = s; paddle_x = 11'(px); vblnk_in = 1'b1;
    model_frame(s, px);
    repeat (hold) @(negedge pclk);
    vblnk_in = 1'b0;
    start = 1'($urandom);
    repeat (3) @(negedge pclk);
    start = 1'b0;
  endtask

  initial begin
    int px, r, tries;
    bit s;
    reset_n = 1'b0; vblnk_in = 1'b0; start = 1'b0; paddle_x = 11'd360;
    model_reset();
    repeat (3) @(negedge pclk);
    chk("rst_x", int'(ball_x), 400);
    chk("rst_y", int'(ball_y), 549);
    chk("rst_lives", int'(lives), 3);
    chk("rst_state", int'(game_state), IDLE);
    chk("rst_lost", int'(ball_lost), 0);
    reset_n = 1'b1;

    repeat (3) frame(1'b0, 360, 1);
    chk("t1_x", int'(ball_x), 400);
    chk("t1_y", int'(ball_y), 549);

    frame(1'b0, 100, 1);
    chk("t2_centre_x", int'(ball_x), 140);
    frame(1'b1, 100, 1);
    chk("t2_state", int'(game_state), MOVE);
    frame(1'b0, 100, 1);
    chk("t2_step_x", int'(ball_x), 144);
    chk("t2_step_y", int'(ball_y), 545);

    for (int i = 0; i < 600; i++) begin
      if (m_st == MOVE && ($urandom % 4) != 0) begin
        r = int'($urandom_range(0, 79));
        px = m_x - r;
        if (px < 0) px = 0;
        if (px > 720) px = 720;
      end else begin
        px = int'($urandom_range(0, 720));
      end
      s = (($urandom % 3) == 0);
      frame(s, px, 1 + int'($urandom % 3));
    end

    repeat (4) frame(1'b1, 300, 10);

    tries = 0;
    while (m_st != MOVE && tries < 20) begin
      frame(1'b1, 300, 1);
      tries++;
    end
    chk("reach_move", m_st, MOVE);
    repeat (5) frame(1'b0, 300, 1);
    @(posedge pclk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_x", int'(ball_x), 400);
    chk("async_rst_y", int'(ball_y), 549);
    chk("async_rst_lives", int'(lives), 3);
    chk("async_rst_state", int'(game_state), IDLE);
    chk("async_rst_lost", int'(ball_lost), 0);
    chk("queue_drained", q.size(), 0);
    model_reset();
    @(negedge pclk);
    reset_n = 1'b1;

    frame(1'b0, 200, 10);
    chk("hold_x", int'(ball_x), 240);
    frame(1'b1, 200, 1);
    repeat (10) frame(1'b0, 200, 1);

    repeat (4) @(negedge pclk);
    chk("final_queue", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
